pmem_responder: RTL

// - Physical-memory responder: the far end of the cache's pmem_read/pmem_write/pmem_resp line interface.
// - Stores LINES x 256-bit lines and serves whole-line reads and writes after a fixed latency.
// - Replaces the behavioural memory model in synthesizable system builds and in cache-level benches.
// - Sits directly between a cache's pmem_* ports and nothing else. No arbitration.

---
 rtl/pmem_responder_if.sv | 34 +++
 rtl/pmem_responder.sv | 115 +++++++++++
 2 files changed

// File: rtl/pmem_responder_if.sv
// Purpose : line-granular pmem request/response bundle between a cache and its backing memory.
// Latency : none, wires only.
// Backpressure: the initiator holds read/write until the one-cycle resp pulse.
interface pmem_responder_if;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;
   logic         pmem_error;

   // Cache side: issues requests, consumes completions.
   modport master (
      output pmem_read,
      output pmem_write,
      output pmem_address,
      output pmem_wdata,
      input  pmem_rdata,
      input  pmem_resp,
      input  pmem_error
   );

   // Memory side: accepts requests, returns completions.
   modport slave (
      input  pmem_read,
      input  pmem_write,
      input  pmem_address,
      input  pmem_wdata,
      output pmem_rdata,
      output pmem_resp,
      output pmem_error
   );
endinterface

// File: rtl/pmem_responder.sv
// Purpose : synthesizable whole-line memory answering a cache's pmem read/write port.
// Latency : pmem_resp is sampled high LATENCY edges after the accepting edge; one recovery cycle follows.
// Backpressure: one request at a time; inputs are ignored outside IDLE, so the initiator must hold until resp.
module pmem_responder #(
   parameter int LINES   = 32,
   parameter int LATENCY = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   pmem_responder_if.slave bus
);

   localparam int IDX_W = $clog2(LINES);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RESP    = 2'd2,
      RECOVER = 2'd3
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               op_wr;
   logic [IDX_W-1:0]   idx_q;
   logic [255:0]       wdata_q;
   logic [255:0]       rdata_q;
   logic               resp_q;
   logic               error_q;

   // Line storage; deliberately not reset, contents are undefined until written.
   logic [255:0]       mem [LINES];

   logic [IDX_W-1:0]   req_idx;
   logic               req_any;
   logic               unused_addr;

   // Only the line index bits matter; offset bits and high bits alias away.
   assign req_idx     = bus.pmem_address[5 +: IDX_W];
   assign req_any     = bus.pmem_read | bus.pmem_write;
   assign unused_addr = ^{bus.pmem_address[31:5+IDX_W], bus.pmem_address[4:0]};

   assign bus.pmem_rdata = rdata_q;
   assign bus.pmem_resp  = resp_q;
   assign bus.pmem_error = error_q;

   // Request FSM: accept in IDLE, count down in BUSY, pulse resp in RESP, swallow the held request in RECOVER.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         op_wr   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         resp_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         resp_q <= 1'b0;
         case (state)
            IDLE: begin
               if (req_any) begin
                  // A write wins a read/write collision; the collision itself is flagged stickily.
                  op_wr   <= bus.pmem_write;
                  idx_q   <= req_idx;
                  wdata_q <= bus.pmem_wdata;
                  if (bus.pmem_read && bus.pmem_write) begin
                     error_q <= 1'b1;
                  end
                  if (LATENCY == 1) begin
                     // No BUSY phase: the read data must come straight from the live index.
                     state  <= RESP;
                     resp_q <= 1'b1;
                     if (!bus.pmem_write) begin
                        rdata_q <= mem[req_idx];
                     end
                  end else begin
                     state <= BUSY;
                     cnt   <= CNT_W'(LATENCY - 1);
                  end
               end
            end
            BUSY: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state  <= RESP;
                  resp_q <= 1'b1;
                  if (!op_wr) begin
                     rdata_q <= mem[idx_q];
                  end
               end
            end
            RESP: begin
               state <= RECOVER;
            end
            RECOVER: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Write commit on the edge leaving RESP, so a following read always sees it;
   // a reset mid-operation forces IDLE first, which drops the pending write.
   always_ff @(posedge clk) begin
      if (state == RESP && op_wr) begin
         mem[idx_q] <= wdata_q;
      end
   end

endmodule
